// File: rtl/psc_pkg.sv
// Shared types for the stpt DAC setpoint sequencer: opmode decode, FSM states, DAC code width.
package psc_pkg;

    localparam int unsigned DAC_W = 20;

    // Opmodes 1 and 2 are not named; anything other than OP_JUMP behaves as OP_SMOOTH.
    typedef enum logic [1:0] {
        OP_SMOOTH = 2'd0,
        OP_JUMP   = 2'd3
    } opmode_t;

    typedef enum logic [2:0] {
        StIdle,
        StSlew,
        StRampRd,
        StRampWait,
        StRampIssue
    } seq_state_t;

endpackage

// File: rtl/dac_stpt_sequencer_if.sv
// Valid/ready stream from the setpoint sequencer to the DAC serial writer.
interface dac_stpt_sequencer_if
    import psc_pkg::*;
#(
    parameter int unsigned DATA_W = DAC_W
);
    logic [DATA_W-1:0] dac_data;
    logic              dac_valid;
    logic              dac_ready;

    modport master (
        output dac_data,
        output dac_valid,
        input  dac_ready
    );

    modport slave (
        input  dac_data,
        input  dac_valid,
        output dac_ready
    );
endinterface

// File: rtl/dac_slew_limiter.sv
// Combinational slew step: moves cur toward target by at most slew_step, never overshooting.
module dac_slew_limiter #(
    parameter int unsigned DATA_W = 20
) (
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] slew_step,
    output logic [DATA_W-1:0] next_val
);
    // One extra bit so target-cur cannot wrap for full-scale two's complement codes.
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step;
    logic signed [DATA_W:0] delta;
    logic signed [DATA_W:0] sum;
    logic                   unused_sum_msb;

    always_comb begin
        diff = {target[DATA_W-1], target} - {cur[DATA_W-1], cur};
        step = {1'b0, slew_step};
        if (diff > step) begin
            delta = step;
        end else if (diff < -step) begin
            delta = -step;
        end else begin
            delta = diff;
        end
        sum      = {cur[DATA_W-1], cur} + delta;
        next_val = sum[DATA_W-1:0];
    end

    // Result lies between cur and target, so the extension bit carries no information.
    assign unused_sum_msb = sum[DATA_W];

endmodule

// File: rtl/dac_stpt_sequencer.sv
// Per-channel setpoint sequencer (JUMP / SMOOTH / RAMP) feeding the stpt DAC writer.
// Build option RAMP_TRIG_EN: a rising edge on trig starts ramp playback like ramp_run.
module dac_stpt_sequencer
    import psc_pkg::*;
#(
    parameter int unsigned DATA_W = DAC_W,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            opmode,
    input  logic                  stpt_wr,
    input  logic [DATA_W-1:0]     stpt,
    input  logic [DATA_W-1:0]     slew_step,
    input  logic [ADDR_W:0]       ramp_len,
    input  logic                  ramp_run,
    input  logic                  trig,
    input  logic                  tick,
    output logic [ADDR_W-1:0]     rt_addr,
    input  logic [DATA_W-1:0]     rt_rdata,
    dac_stpt_sequencer_if.master  dac,
    output logic                  ramp_active,
    output logic                  ramp_done,
    output logic [15:0]           tick_ovr,
    output logic                  wr_drop
);
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IdxOne = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] cur_q, cur_d, target_q, target_d, dac_data_q, dac_data_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d, idx_inc;
    logic              dac_valid_q, dac_valid_d, ramp_done_q, ramp_done_d;
    logic              jump_pend_q, jump_pend_d, wr_drop_q, wr_drop_d;
    logic [15:0]       tick_ovr_q, tick_ovr_d;

    logic              is_jump, in_ramp, slot_free, tick_ok, accept, start_req;
    logic              ramp_start, smooth_wr, slew_go, last_entry;
    logic [DATA_W-1:0] target_eff, slew_next;

`ifdef RAMP_TRIG_EN
    logic trig_q;
    always_ff @(posedge clk) begin
        if (!reset_n) trig_q <= 1'b0;
        else          trig_q <= trig;
    end
    assign start_req = ramp_run | (trig & ~trig_q);
`else
    logic unused_trig;
    assign unused_trig = trig;
    assign start_req   = ramp_run;
`endif

    assign is_jump    = (opmode == OP_JUMP);
    assign in_ramp    = (state_q == StRampRd) || (state_q == StRampWait) ||
                        (state_q == StRampIssue);
    assign accept     = dac_valid_q && dac.dac_ready;
    // The output slot can take a new value if empty or being accepted this clock.
    assign slot_free  = !dac_valid_q || dac.dac_ready;
    assign tick_ok    = tick && slot_free;
    assign ramp_start = start_req && !is_jump && !in_ramp && (ramp_len != '0);
    assign smooth_wr  = stpt_wr && !is_jump && !in_ramp;
    assign slew_go    = !is_jump && !ramp_start && tick_ok && ((state_q == StSlew) || smooth_wr);
    assign target_eff = smooth_wr ? stpt : target_q;
    assign idx_inc    = idx_q + IdxOne;
    assign last_entry = (idx_inc == len_q);

    dac_slew_limiter #(
        .DATA_W (DATA_W)
    ) u_slew (
        .target    (target_eff),
        .cur       (cur_q),
        .slew_step (slew_step),
        .next_val  (slew_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StSlew: begin
                if (is_jump) begin
                    state_d = StIdle;
                end else if (ramp_start) begin
                    state_d = StRampRd;
                end else begin
                    if (smooth_wr) state_d = StSlew;
                    if (slew_go && (slew_next == target_eff)) state_d = StIdle;
                end
            end
            StRampRd:    state_d = is_jump ? StIdle : StRampWait;
            StRampWait: begin
                if (is_jump)      state_d = StIdle;
                else if (tick_ok) state_d = StRampIssue;
            end
            StRampIssue: begin
                if (is_jump)     state_d = StIdle;
                else if (accept) state_d = last_entry ? StIdle : StRampRd;
            end
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        rt_addr     = idx_q[ADDR_W-1:0];
        ramp_active = in_ramp;
    end

    always_comb begin
        cur_d       = cur_q;
        target_d    = target_q;
        idx_d       = idx_q;
        len_d       = len_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = dac_valid_q && !dac.dac_ready;
        jump_pend_d = jump_pend_q;
        ramp_done_d = 1'b0;
        tick_ovr_d  = tick_ovr_q;
        wr_drop_d   = wr_drop_q;

        if (tick && !slot_free && (tick_ovr_q != 16'hFFFF)) tick_ovr_d = tick_ovr_q + 16'd1;
        if (stpt_wr && in_ramp && !is_jump) wr_drop_d = 1'b1;

        if (is_jump) begin
            // A jump that finds the slot busy is remembered and issued once it frees up.
            if (stpt_wr) begin
                cur_d       = stpt;
                target_d    = stpt;
                jump_pend_d = 1'b1;
            end
            if ((stpt_wr || jump_pend_q) && slot_free) begin
                dac_data_d  = stpt_wr ? stpt : cur_q;
                dac_valid_d = 1'b1;
                jump_pend_d = 1'b0;
            end
        end else begin
            jump_pend_d = 1'b0;
            if (ramp_start) begin
                idx_d = '0;
                len_d = (ramp_len > MaxLen) ? MaxLen : ramp_len;
            end else if (smooth_wr) begin
                target_d = stpt;
            end
            if (slew_go) begin
                cur_d       = slew_next;
                dac_data_d  = slew_next;
                dac_valid_d = 1'b1;
            end
            if ((state_q == StRampWait) && tick_ok) begin
                dac_data_d  = rt_rdata;
                dac_valid_d = 1'b1;
            end
            if ((state_q == StRampIssue) && accept) begin
                cur_d = dac_data_q;
                idx_d = idx_inc;
                if (last_entry) begin
                    target_d    = dac_data_q;
                    ramp_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_q       <= '0;
            target_q    <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            jump_pend_q <= 1'b0;
            ramp_done_q <= 1'b0;
            tick_ovr_q  <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            target_q    <= target_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            jump_pend_q <= jump_pend_d;
            ramp_done_q <= ramp_done_d;
            tick_ovr_q  <= tick_ovr_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    assign dac.dac_data  = dac_data_q;
    assign dac.dac_valid = dac_valid_q;
    assign ramp_done     = ramp_done_q;
    assign tick_ovr      = tick_ovr_q;
    assign wr_drop       = wr_drop_q;

endmodule

// File: tb/tb_dac_stpt_sequencer.sv
// Scoreboard bench for dac_stpt_sequencer: expected DAC codes queued at stimulus, popped on accept.
module tb_dac_stpt_sequencer;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        opmode;
    logic              stpt_wr;
    logic [DATA_W-1:0] stpt;
    logic [DATA_W-1:0] slew_step;
    logic [ADDR_W:0]   ramp_len;
    logic              ramp_run;
    logic              trig;
    logic              tick;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rt_rdata;
    logic              ramp_active;
    logic              ramp_done;
    logic [15:0]       tick_ovr;
    logic              wr_drop;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    dac_stpt_sequencer_if #(.DATA_W(DATA_W)) dac ();

    dac_stpt_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opmode      (opmode),
        .stpt_wr     (stpt_wr),
        .stpt        (stpt),
        .slew_step   (slew_step),
        .ramp_len    (ramp_len),
        .ramp_run    (ramp_run),
        .trig        (trig),
        .tick        (tick),
        .rt_addr     (rt_addr),
        .rt_rdata    (rt_rdata),
        .dac         (dac),
        .ramp_active (ramp_active),
        .ramp_done   (ramp_done),
        .tick_ovr    (tick_ovr),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    // Ramp BRAM model: table[i] = i + 10, one clock read latency.
    always @(posedge clk) rt_rdata <= {{(DATA_W-ADDR_W){1'b0}}, rt_addr} + 20'd10;

    always @(negedge clk) begin
        if (reset_n && dac.dac_valid && dac.dac_ready) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dac_accept: unexpected value %h, none queued", dac.dac_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dac.dac_data !== mon_exp) begin
                    failures++;
                    $display("FAIL dac_accept: got %h expected %h", dac.dac_data, mon_exp);
                end
            end
        end
        if (reset_n && ramp_done) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opmode = 2'd0; stpt_wr = 1'b0; stpt = '0; slew_step = '0;
        ramp_len = '0; ramp_run = 1'b0; trig = 1'b0; tick = 1'b0; dac.dac_ready = 1'b1;
        cyc(3);
        checks++;
        if ({dac.dac_valid, dac.dac_data} !== 21'd0) begin
            failures++;
            $display("FAIL reset_dac: got %b/%h expected 0/0", dac.dac_valid, dac.dac_data);
        end
        checks++;
        if ({ramp_active, ramp_done, wr_drop, tick_ovr, rt_addr} !== 33'd0) begin
            failures++;
            $display("FAIL reset_status: act=%b done=%b drop=%b ovr=%h addr=%h expected all 0",
                     ramp_active, ramp_done, wr_drop, tick_ovr, rt_addr);
        end
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_jump();
        int acc0 = acc_cnt;
        opmode = psc_pkg::OP_JUMP;
        stpt = 20'h01234; stpt_wr = 1'b1; exp_q.push_back(20'h01234);
        cyc(1);
        checks++;
        if (dac.dac_valid !== 1'b1) begin
            failures++;
            $display("FAIL jump_latency: dac_valid=%b expected 1", dac.dac_valid);
        end
        stpt = 20'h01000; exp_q.push_back(20'h01000);
        cyc(1);
        stpt_wr = 1'b0;
        cyc(3);
        checks++;
        if ((acc_cnt - acc0) !== 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL jump_count: accepted %0d expected 2, %0d left", acc_cnt - acc0,
                     exp_q.size());
        end
    endtask

    task automatic test_smooth();
        int acc0;
        pulse_reset();
        opmode = psc_pkg::OP_SMOOTH; slew_step = 20'h00100;
        stpt = 20'h00380; stpt_wr = 1'b1;
        cyc(1);
        stpt_wr = 1'b0;
        cyc(2);
        exp_q.push_back(20'h00100); exp_q.push_back(20'h00200);
        exp_q.push_back(20'h00300); exp_q.push_back(20'h00380);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            cyc(3);
        end
        acc0 = acc_cnt;
        do_tick();
        cyc(3);
        checks++;
        if (acc_cnt !== acc0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL smooth_idle: %0d issued after target, %0d left, expected 0/0",
                     acc_cnt - acc0, exp_q.size());
        end
        // Write and tick together: the tick slews toward the new target.
        exp_q.push_back(20'h00280); exp_q.push_back(20'h00180); exp_q.push_back(20'h00100);
        stpt = 20'h00100; stpt_wr = 1'b1; tick = 1'b1;
        cyc(1);
        stpt_wr = 1'b0; tick = 1'b0;
        cyc(3);
        for (int i = 0; i < 2; i++) begin
            do_tick();
            cyc(3);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL smooth_down: %0d values not issued, expected 0", exp_q.size());
        end
    endtask

    task automatic test_ramp();
        int done0 = done_cnt;
        opmode = psc_pkg::OP_SMOOTH; ramp_len = 15'd10; ramp_run = 1'b1;
        cyc(1);
        ramp_run = 1'b0;
        checks++;
        if (ramp_active !== 1'b1) begin
            failures++;
            $display("FAIL ramp_start: ramp_active=%b expected 1", ramp_active);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(3);
            checks++;
            if (rt_addr !== 14'(i)) begin
                failures++;
                $display("FAIL ramp_addr: rt_addr=%0d expected %0d", rt_addr, i);
            end
            exp_q.push_back(20'(i + 10));
            do_tick();
        end
        cyc(3);
        checks++;
        if ((done_cnt - done0) !== 1 || ramp_active !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ramp_end: done pulses=%0d active=%b left=%0d expected 1/0/0",
                     done_cnt - done0, ramp_active, exp_q.size());
        end
        // cur must now be 19: a step of 2 toward 25 yields 21.
        slew_step = 20'd2; stpt = 20'd25; exp_q.push_back(20'd21);
        stpt_wr = 1'b1; tick = 1'b1;
        cyc(1);
        stpt_wr = 1'b0; tick = 1'b0;
        cyc(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ramp_final_cur: %0d values not issued, expected 0", exp_q.size());
        end
    endtask

    task automatic test_tick_ovr();
        pulse_reset();
        opmode = psc_pkg::OP_JUMP; dac.dac_ready = 1'b0;
        stpt = 20'h00055; stpt_wr = 1'b1; exp_q.push_back(20'h00055);
        cyc(1);
        stpt_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            cyc(1);
        end
        checks++;
        if (tick_ovr !== 16'd3) begin
            failures++;
            $display("FAIL tick_ovr_count: got %0d expected 3", tick_ovr);
        end
        checks++;
        if (dac.dac_valid !== 1'b1 || dac.dac_data !== 20'h00055) begin
            failures++;
            $display("FAIL tick_ovr_hold: valid=%b data=%h expected 1/00055", dac.dac_valid,
                     dac.dac_data);
        end
        dac.dac_ready = 1'b1;
        cyc(2);
        do_tick();
        cyc(1);
        checks++;
        if (tick_ovr !== 16'd3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL tick_ovr_after: ovr=%0d left=%0d expected 3/0", tick_ovr,
                     exp_q.size());
        end
    endtask

    task automatic test_ramp_drop_abort();
        int done0;
        pulse_reset();
        done0 = done_cnt;
        opmode = psc_pkg::OP_SMOOTH; ramp_len = 15'd10; ramp_run = 1'b1;
        cyc(1);
        ramp_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(3);
            exp_q.push_back(20'(i + 10));
            do_tick();
            if (i == 1) begin
                stpt = 20'h00777; stpt_wr = 1'b1;
                cyc(1);
                stpt_wr = 1'b0;
            end
        end
        cyc(3);
        checks++;
        if (wr_drop !== 1'b1) begin
            failures++;
            $display("FAIL wr_drop_set: got %b expected 1", wr_drop);
        end
        opmode = psc_pkg::OP_JUMP;
        cyc(1);
        checks++;
        if (ramp_active !== 1'b0) begin
            failures++;
            $display("FAIL jump_abort: ramp_active=%b expected 0", ramp_active);
        end
        opmode = psc_pkg::OP_SMOOTH;
        cyc(3);
        checks++;
        if (done_cnt !== done0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d left=%0d expected 0/0",
                     done_cnt - done0, exp_q.size());
        end
        // Held cur is 13, so a unit step toward 0x20 yields 14.
        slew_step = 20'd1; stpt = 20'h00020; exp_q.push_back(20'd14);
        stpt_wr = 1'b1; tick = 1'b1;
        cyc(1);
        stpt_wr = 1'b0; tick = 1'b0;
        cyc(3);
        checks++;
        if (exp_q.size() != 0 || wr_drop !== 1'b1) begin
            failures++;
            $display("FAIL abort_cur: left=%0d wr_drop=%b expected 0/1", exp_q.size(), wr_drop);
        end
    endtask

    task automatic test_reset_mid_ramp();
        int acc0;
        int done0;
        pulse_reset();
        opmode = psc_pkg::OP_SMOOTH; ramp_len = 15'd10; ramp_run = 1'b1;
        cyc(1);
        ramp_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(3);
            exp_q.push_back(20'(i + 10));
            do_tick();
        end
        cyc(3);
        dac.dac_ready = 1'b0;
        do_tick();
        checks++;
        if (dac.dac_valid !== 1'b1 || dac.dac_data !== 20'd15 || rt_addr !== 14'd5) begin
            failures++;
            $display("FAIL ramp_idx5: valid=%b data=%h addr=%0d expected 1/0000f/5",
                     dac.dac_valid, dac.dac_data, rt_addr);
        end
        reset_n = 1'b0;
        cyc(1);
        checks++;
        if ({dac.dac_valid, dac.dac_data, ramp_active, rt_addr, tick_ovr} !== 52'd0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b data=%h act=%b addr=%h ovr=%h expected all 0",
                     dac.dac_valid, dac.dac_data, ramp_active, rt_addr, tick_ovr);
        end
        dac.dac_ready = 1'b1;
        reset_n = 1'b1;
        cyc(1);
        acc0 = acc_cnt; done0 = done_cnt;
        ramp_len = '0; ramp_run = 1'b1;
        cyc(1);
        ramp_run = 1'b0;
        checks++;
        if (ramp_active !== 1'b0) begin
            failures++;
            $display("FAIL len0_start: ramp_active=%b expected 0", ramp_active);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(3);
            do_tick();
        end
        cyc(3);
        checks++;
        if (acc_cnt !== acc0 || done_cnt !== done0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL len0_idle: issued=%0d done=%0d left=%0d expected 0/0/0",
                     acc_cnt - acc0, done_cnt - done0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_smooth();
        test_ramp();
        test_tick_ovr();
        test_ramp_drop_abort();
        test_reset_mid_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
